// File: rtl/mmio_uart_ctrl.sv
// Memory-mapped I/O block for the Riscv151 EX/MEM stage: UART TX holding register,
// RX FIFO and cycle/instret counters, with load data registered one cycle later.
module mmio_uart_ctrl #(
  parameter int RX_DEPTH  = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_we,
  input  logic        io_re,
  input  logic        inst_retire,
  output logic [31:0] io_rdata,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
);

  localparam int PTR_W = $clog2(RX_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(RX_DEPTH);

  localparam logic [7:0] OFF_STATUS  = 8'h00;
  localparam logic [7:0] OFF_RX      = 8'h04;
  localparam logic [7:0] OFF_TX      = 8'h08;
  localparam logic [7:0] OFF_CYCLE   = 8'h10;
  localparam logic [7:0] OFF_INSTRET = 8'h14;
  localparam logic [7:0] OFF_CLEAR   = 8'h18;

  logic       hit;
  logic       store;
  logic       load;
  logic [7:0] offset;

  logic       tx_valid_reg;
  logic [7:0] tx_data_reg;
  logic       tx_accept;

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             ready_en_reg;
  logic             rx_nonempty;
  logic             push;
  logic             pop;

  logic [CNT_WIDTH-1:0] cycle_reg;
  logic [CNT_WIDTH-1:0] instret_reg;
  logic                 cnt_clear;

  logic [31:0] rdata_next;
  logic [31:0] rdata_reg;
  logic        unused_bits;

  assign unused_bits = ^{io_addr[30:8], io_wdata[31:8]};

  assign hit    = io_addr[31];
  assign offset = io_addr[7:0];
  assign store  = hit && (|io_we);
  // A combined load+store performs only the store; the load is squashed.
  assign load   = hit && io_re && !(|io_we);

  // ---------------- TX holding register ----------------
  assign tx_accept     = store && (offset == OFF_TX) && !tx_valid_reg;
  assign uart_tx_valid = tx_valid_reg;
  assign uart_tx_data  = tx_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
    end else if (tx_accept) begin
      tx_valid_reg <= 1'b1;
      tx_data_reg  <= io_wdata[7:0];
    end else if (tx_valid_reg && uart_tx_ready) begin
      tx_valid_reg <= 1'b0;
    end
  end

  // ---------------- RX FIFO ----------------
  // ready_en keeps the receiver stalled while reset is asserted even though count is 0.
  assign rx_nonempty   = (count_reg != '0);
  assign uart_rx_ready = ready_en_reg && (count_reg != FIFO_FULL);
  assign push          = uart_rx_valid && uart_rx_ready;
  assign pop           = load && (offset == OFF_RX) && rx_nonempty;

  always_ff @(posedge clk) begin
    if (push) begin
      rx_mem[wr_ptr_reg] <= uart_rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------- Counters ----------------
  assign cnt_clear = store && (offset == OFF_CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_reg   <= '0;
      instret_reg <= '0;
    end else if (cnt_clear) begin
      cycle_reg   <= '0;
      instret_reg <= '0;
    end else begin
      cycle_reg   <= cycle_reg + 1'b1;
      instret_reg <= instret_reg + CNT_WIDTH'(inst_retire);
    end
  end

  // ---------------- Load data path ----------------
  always_comb begin
    rdata_next = 32'h0;
    if (load) begin
      case (offset)
        OFF_STATUS:  rdata_next = {30'b0, rx_nonempty, ~tx_valid_reg};
        OFF_RX:      rdata_next = rx_nonempty ? {24'b0, rx_mem[rd_ptr_reg]} : 32'h0;
        OFF_CYCLE:   rdata_next = 32'(cycle_reg);
        OFF_INSTRET: rdata_next = 32'(instret_reg);
        default:     rdata_next = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= 32'h0;
    end else begin
      rdata_reg <= rdata_next;
    end
  end

  assign io_rdata = rdata_reg;

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed bench for mmio_uart_ctrl; counters narrowed to 8 bits so the wrap
// is reachable in a few hundred cycles.
module tb_mmio_uart_ctrl;

  localparam logic [31:0] A_STATUS  = 32'h8000_0000;
  localparam logic [31:0] A_RX      = 32'h8000_0004;
  localparam logic [31:0] A_TX      = 32'h8000_0008;
  localparam logic [31:0] A_CYCLE   = 32'h8000_0010;
  localparam logic [31:0] A_INSTRET = 32'h8000_0014;
  localparam logic [31:0] A_CLEAR   = 32'h8000_0018;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] io_addr = '0;
  logic [31:0] io_wdata = '0;
  logic [3:0]  io_we = '0;
  logic        io_re = 1'b0;
  logic        inst_retire = 1'b0;
  logic [31:0] io_rdata;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_valid = 1'b0;
  logic        uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  mmio_uart_ctrl #(.RX_DEPTH(8), .CNT_WIDTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .io_addr       (io_addr),
    .io_wdata      (io_wdata),
    .io_we         (io_we),
    .io_re         (io_re),
    .inst_retire   (inst_retire),
    .io_rdata      (io_rdata),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] a);
    io_addr = a;
    io_re   = 1'b1;
    tick();
    io_re   = 1'b0;
    io_addr = '0;
    $display("load  addr=0x%08h rdata=0x%08h", a, io_rdata);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    io_addr  = a;
    io_wdata = d;
    io_we    = 4'hF;
    tick();
    io_we    = '0;
    io_addr  = '0;
    io_wdata = '0;
    $display("store addr=0x%08h wdata=0x%08h tx_valid=%0b", a, d, uart_tx_valid);
  endtask

  initial begin
    // 1. Reset behaviour, including reset while a TX byte is held
    tick();
    tick();
    check("rst_rx_ready", 32'(uart_rx_ready), 32'd0);
    check("rst_rdata", io_rdata, 32'h0);
    check("rst_tx_valid", 32'(uart_tx_valid), 32'd0);
    rst_n = 1'b1;
    do_load(A_CYCLE);
    check("cycle_first", io_rdata, 32'd0);
    check("rx_ready_after_rst", 32'(uart_rx_ready), 32'd1);
    do_load(A_CYCLE);
    check("cycle_second", io_rdata, 32'd1);
    do_store(A_TX, 32'h55);
    check("pre_rst_tx_valid", 32'(uart_tx_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_tx_valid", 32'(uart_tx_valid), 32'd0);
    check("midrst_tx_data", 32'(uart_tx_data), 32'h0);
    check("midrst_rx_ready", 32'(uart_rx_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    do_load(A_CYCLE);
    check("cycle_restart", io_rdata, 32'd0);
    do_load(A_STATUS);
    check("status_after_rst", io_rdata, 32'h1);

    // 2. TX holding register
    do_store(A_TX, 32'h41);
    check("tx_valid_set", 32'(uart_tx_valid), 32'd1);
    check("tx_data_41", 32'(uart_tx_data), 32'h41);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("tx_hold_valid", 32'(uart_tx_valid), 32'd1);
      check("tx_hold_data", 32'(uart_tx_data), 32'h41);
    end
    do_store(A_TX, 32'h42);
    check("tx_drop_data", 32'(uart_tx_data), 32'h41);
    do_load(A_STATUS);
    check("status_tx_busy", io_rdata, 32'h0);
    uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0;
    check("tx_valid_cleared", 32'(uart_tx_valid), 32'd0);
    do_load(A_STATUS);
    check("status_tx_free", io_rdata, 32'h1);
    tick();
    check("rdata_idle_zero", io_rdata, 32'h0);
    do_store(A_TX, 32'h77);
    uart_tx_ready = 1'b1;
    do_store(A_TX, 32'h88);
    uart_tx_ready = 1'b0;
    check("tx_handshake_store_valid", 32'(uart_tx_valid), 32'd0);
    check("tx_handshake_store_data", 32'(uart_tx_data), 32'h77);

    // 3. RX fill, overflow and ordered drain
    for (int i = 0; i < 8; i++) begin
      uart_rx_valid = 1'b1;
      uart_rx_data  = 8'h10 + 8'(i);
      tick();
      $display("push  data=0x%02h ready=%0b", uart_rx_data, uart_rx_ready);
    end
    check("rx_full_ready", 32'(uart_rx_ready), 32'd0);
    uart_rx_data = 8'h18;
    tick();
    uart_rx_valid = 1'b0;
    check("rx_overflow_ready", 32'(uart_rx_ready), 32'd0);
    do_load(A_STATUS);
    check("status_rx_full", io_rdata, 32'h3);
    for (int i = 0; i < 8; i++) begin
      do_load(A_RX);
      check("rx_pop", io_rdata, 32'h10 + 32'(i));
    end
    do_load(A_RX);
    check("rx_pop_empty", io_rdata, 32'h0);
    do_load(A_STATUS);
    check("status_rx_empty", io_rdata, 32'h1);

    // 4. Pop and push in the same cycle while full
    for (int i = 0; i < 8; i++) begin
      uart_rx_valid = 1'b1;
      uart_rx_data  = 8'h20 + 8'(i);
      tick();
    end
    check("rx_full2_ready", 32'(uart_rx_ready), 32'd0);
    uart_rx_data = 8'h30;
    io_addr = A_RX;
    io_re   = 1'b1;
    tick();
    io_re   = 1'b0;
    io_addr = '0;
    check("rx_simul_pop", io_rdata, 32'h20);
    check("rx_simul_ready", 32'(uart_rx_ready), 32'd1);
    tick();
    uart_rx_valid = 1'b0;
    check("rx_refill_ready", 32'(uart_rx_ready), 32'd0);
    for (int i = 0; i < 8; i++) begin
      do_load(A_RX);
      check("rx_drain2", io_rdata, (i < 7) ? (32'h21 + 32'(i)) : 32'h30);
    end
    do_load(A_RX);
    check("rx_drain2_empty", io_rdata, 32'h0);

    // 5. Counters: wrap, retire counting and clear priority
    do_store(A_CLEAR, 32'h0);
    repeat (254) tick();
    do_load(A_CYCLE);
    check("cycle_fe", io_rdata, 32'hFE);
    do_load(A_CYCLE);
    check("cycle_ff", io_rdata, 32'hFF);
    do_load(A_CYCLE);
    check("cycle_wrap", io_rdata, 32'h00);
    do_load(A_INSTRET);
    check("instret_zero", io_rdata, 32'd0);
    inst_retire = 1'b1;
    repeat (3) tick();
    inst_retire = 1'b0;
    do_load(A_INSTRET);
    check("instret_three", io_rdata, 32'd3);
    inst_retire = 1'b1;
    do_store(A_CLEAR, 32'h0);
    inst_retire = 1'b0;
    do_load(A_INSTRET);
    check("instret_cleared", io_rdata, 32'd0);
    do_load(A_CYCLE);
    check("cycle_after_clear", io_rdata, 32'd1);

    // 6. Address decode
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'h5A;
    tick();
    uart_rx_valid = 1'b0;
    do_load(32'h0000_0004);
    check("nonmmio_load", io_rdata, 32'h0);
    do_load(32'h8000_0020);
    check("unmapped_load", io_rdata, 32'h0);
    do_load(A_STATUS);
    check("status_fifo_untouched", io_rdata, 32'h3);
    do_load(A_RX);
    check("rx_after_decode", io_rdata, 32'h5A);
    do_store(32'h0000_0008, 32'h99);
    check("nonmmio_store", 32'(uart_tx_valid), 32'd0);
    io_addr  = A_TX;
    io_wdata = 32'h66;
    io_we    = 4'hF;
    io_re    = 1'b1;
    tick();
    io_we    = '0;
    io_re    = 1'b0;
    io_addr  = '0;
    check("rw_same_rdata", io_rdata, 32'h0);
    check("rw_same_tx_valid", 32'(uart_tx_valid), 32'd1);
    check("rw_same_tx_data", 32'(uart_tx_data), 32'h66);
    uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
